uart_echo_fifo: RTL and testbench
=================================

Name: uart_echo_fifo

Overview:
- Parametrised UART echo block: receives serial frames, buffers good bytes in a FIFO, retransmits them in order on the TX line.
- Successor to the fixed 8N1 rx-to-tx loopback top. Adds a reset, configurable frame format (data bits, parity, stop bits), a receive FIFO, TX flow-control hold, and sticky error reporting.
- Sits at the board-level serial interface as a self-contained echo/relay endpoint.

Parameters:
- CLKS_PER_BIT, 87, clock cycles per bit (>=4).
- DATA_BITS, 8, data bits per frame (5..8).
- PARITY_MODE, 0, 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, stop bits emitted by TX (1 or 2). RX checks only the first stop bit.
- FIFO_DEPTH, 16, FIFO entries (power of two, >=2).

Ports:
- i_Clock  input  1  system clock; sole clock.
- i_Rst_n  input  1  asynchronous active-low reset.
- i_Rx_Serial  input  1  asynchronous serial in; idle high.
- i_Tx_Hold  input  1  high = TX must not start a new frame; an in-flight frame completes.
- i_Err_Clr  input  1  one-cycle pulse that clears the sticky error flags.
- o_Rx_DV  output  1  one-cycle pulse when a good byte is received.
- o_Rx_Byte  output  DATA_BITS  last good byte; held until the next good byte.
- o_Tx_Serial  output  1  serial out; idle high.
- o_Tx_Active  output  1  high from the first start-bit cycle through the last stop-bit cycle.
- o_Tx_Done  output  1  one-cycle pulse on the final stop-bit cycle.
- o_Parity_Err  output  1  sticky.
- o_Frame_Err  output  1  sticky.
- o_Overrun  output  1  sticky.
- o_Fifo_Count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async assert, sync release): o_Tx_Serial = 1; every other output = 0; FIFO emptied; both FSMs in IDLE; RX synchroniser flops = 1. Reset mid-frame aborts the frame and nothing is emitted afterwards.
- RX synchroniser: two-flop synchroniser on i_Rx_Serial. All RX logic uses the synchronised bit.
- RX FSM: IDLE -> START -> DATA -> PARITY (only when PARITY_MODE != 0) -> STOP -> IDLE.
  - IDLE -> START on a low sample.
  - START: at count CLKS_PER_BIT/2 (floor), a high sample returns to IDLE (glitch, no flag); a low sample resets the counter and enters DATA.
  - DATA: DATA_BITS samples, LSB first, each taken CLKS_PER_BIT cycles apart (mid-bit).
  - PARITY: one mid-bit sample; mismatch sets o_Parity_Err.
  - STOP: mid-bit sample; a low stop bit sets o_Frame_Err.
  - Return to IDLE on the cycle after the stop sample.
- Error frames: any parity or frame error discards the byte (no o_Rx_DV, no push).
- Good frames: o_Rx_DV pulses on the cycle after the stop sample, o_Rx_Byte updates in the same cycle, and the byte is pushed to the FIFO in the same cycle.
- FIFO full on push: byte dropped, o_Overrun set; o_Rx_DV still pulses.
- Sticky flags: a set and i_Err_Clr in the same cycle leave the flag set.
- FIFO:
  - Circular buffer; pointers wrap modulo FIFO_DEPTH.
  - Push while full is accepted only if a pop happens in the same cycle; count is then unchanged.
  - Pop while empty never happens.
  - Simultaneous push and pop when not full and not empty: count unchanged.
- TX FSM: IDLE -> LOAD -> START -> DATA -> PARITY (if enabled) -> STOP -> IDLE. Each bit state lasts CLKS_PER_BIT cycles.
  - IDLE: if the FIFO is non-empty and i_Tx_Hold = 0, pop and go to LOAD; the head byte is latched into the shift register in LOAD.
  - Data goes out LSB first.
  - Parity bit: even parity = XOR of the data bits; odd parity = its inverse.
  - STOP lasts STOP_BITS*CLKS_PER_BIT cycles; o_Tx_Done pulses on its last cycle.
  - i_Tx_Hold is sampled only in IDLE.
- Latency: o_Rx_DV at cycle N with an empty FIFO, idle TX and no hold: FIFO non-empty at N+1, pop at N+1, LOAD at N+2, first start-bit cycle at N+3.
- Back-to-back frames: two idle-high cycles (IDLE, LOAD) between a stop bit and the next start bit.

Decomposition:
- Shared package uart_pkg:
  - parity-mode constants (PAR_NONE = 0, PAR_ODD = 1, PAR_EVEN = 2);
  - RX state enum and TX state enum;
  - a parity function (data, mode) -> bit.
- Sub-module: uart_sync_fifo (parameters WIDTH and DEPTH; push/pop/full/empty/count).
- RX and TX FSMs stay in uart_echo_fifo.

Test Plan:
- Defaults except CLKS_PER_BIT = 4; send 0xA5 8N1 -> o_Rx_DV with o_Rx_Byte = 0xA5; TX emits start, bits 1,0,1,0,0,1,0,1, stop; o_Tx_Done pulses once; o_Fifo_Count returns to 0.
- PARITY_MODE = 2; send 0x03 with parity bit 1 (wrong) -> no o_Rx_DV, o_Parity_Err = 1, TX stays idle. Pulse i_Err_Clr -> flag clears. Then 0x03 with parity 0 -> echoed with parity bit 0.
- Send 0x55 with stop bit forced low -> o_Frame_Err = 1, byte dropped. Assert i_Err_Clr in the same cycle as the next error -> flag stays 1.
- FIFO_DEPTH = 16; hold i_Tx_Hold = 1; send 18 bytes 0x00..0x11 -> o_Fifo_Count = 16, o_Overrun = 1. Release hold -> 0x00..0x0F transmitted in order with a 2-cycle gap between frames.
- STOP_BITS = 2; send two back-to-back bytes -> each TX frame has 2*CLKS_PER_BIT high stop cycles; o_Tx_Active stays low exactly 2 cycles between frames.
- Assert i_Rst_n low mid-TX data bit -> o_Tx_Serial = 1 immediately, o_Tx_Active = 0, o_Fifo_Count = 0; no further output after release.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, RX/TX state encodings and the parity helper.
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_ODD  = 2'd1;
    localparam logic [1:0] PAR_EVEN = 2'd2;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_LOAD,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    // Unused upper data bits must be zero so they do not disturb the XOR.
    function automatic logic parity_bit(input logic [7:0] data, input logic [1:0] mode);
        logic even;
        even = ^data;
        case (mode)
            PAR_ODD:  return ~even;
            PAR_EVEN: return even;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Circular single-clock FIFO with combinational head read; count updates one cycle after push/pop.
// Push while full is taken only alongside a pop; the caller must never pop while empty.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && (!full || pop);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_echo_fifo.sv
// UART echo: good RX bytes are queued in a FIFO and retransmitted in order; bad frames are dropped.
// Start bit begins 3 cycles after o_Rx_DV when idle; i_Tx_Hold stalls new frames, a full FIFO drops bytes.
module uart_echo_fifo #(
    parameter int CLKS_PER_BIT = 87,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          i_Clock,
    input  logic                          i_Rst_n,
    input  logic                          i_Rx_Serial,
    input  logic                          i_Tx_Hold,
    input  logic                          i_Err_Clr,
    output logic                          o_Rx_DV,
    output logic [DATA_BITS-1:0]          o_Rx_Byte,
    output logic                          o_Tx_Serial,
    output logic                          o_Tx_Active,
    output logic                          o_Tx_Done,
    output logic                          o_Parity_Err,
    output logic                          o_Frame_Err,
    output logic                          o_Overrun,
    output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count
);

    import uart_pkg::*;

    localparam int RXC_W = $clog2(CLKS_PER_BIT);
    localparam int TXC_W = $clog2(STOP_BITS * CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [1:0]       PMODE     = PARITY_MODE[1:0];
    localparam logic [RXC_W-1:0] RX_HALF   = RXC_W'(CLKS_PER_BIT / 2);
    localparam logic [RXC_W-1:0] RX_LAST   = RXC_W'(CLKS_PER_BIT - 1);
    localparam logic [TXC_W-1:0] TX_LAST   = TXC_W'(CLKS_PER_BIT - 1);
    localparam logic [TXC_W-1:0] STOP_LAST = TXC_W'(STOP_BITS * CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

    logic rx_meta, rx_sync;
    rx_state_t rx_state, rx_state_d;
    logic [RXC_W-1:0]     rx_cnt, rx_cnt_d;
    logic [IDX_W-1:0]     rx_idx, rx_idx_d;
    logic [DATA_BITS-1:0] rx_shift, rx_shift_d;
    logic [7:0]           rx_pad;
    logic rx_par_bad, rx_par_bad_d, rx_good, par_set, frm_set, ovr_set;

    tx_state_t tx_state, tx_state_d;
    logic [TXC_W-1:0]     tx_cnt, tx_cnt_d;
    logic [IDX_W-1:0]     tx_idx, tx_idx_d;
    logic [DATA_BITS-1:0] tx_shift, tx_shift_d;
    logic [7:0]           tx_pad;
    logic tx_par, tx_par_d, fifo_pop, fifo_full, fifo_empty;
    logic [DATA_BITS-1:0] fifo_rd_dat;

    always_comb begin
        rx_pad = '0;
        rx_pad[DATA_BITS-1:0] = rx_shift;
        tx_pad = '0;
        tx_pad[DATA_BITS-1:0] = tx_shift;
    end

    always_comb begin
        rx_state_d   = rx_state;
        rx_cnt_d     = rx_cnt + 1'b1;
        rx_idx_d     = rx_idx;
        rx_shift_d   = rx_shift;
        rx_par_bad_d = rx_par_bad;
        rx_good      = 1'b0;
        par_set      = 1'b0;
        frm_set      = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (!rx_sync) rx_state_d = RX_START;
            end
            RX_START: if (rx_cnt == RX_HALF) begin
                rx_cnt_d     = '0;
                rx_idx_d     = '0;
                rx_par_bad_d = 1'b0;
                rx_state_d   = rx_sync ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (rx_cnt == RX_LAST) begin
                rx_cnt_d   = '0;
                rx_shift_d = {rx_sync, rx_shift[DATA_BITS-1:1]};
                rx_idx_d   = rx_idx + 1'b1;
                if (rx_idx == IDX_LAST) rx_state_d = (PARITY_MODE != 0) ? RX_PARITY : RX_STOP;
            end
            RX_PARITY: if (rx_cnt == RX_LAST) begin
                rx_cnt_d   = '0;
                rx_state_d = RX_STOP;
                if (rx_sync != parity_bit(rx_pad, PMODE)) begin
                    rx_par_bad_d = 1'b1;
                    par_set      = 1'b1;
                end
            end
            RX_STOP: if (rx_cnt == RX_LAST) begin
                rx_cnt_d   = '0;
                rx_state_d = RX_IDLE;
                if (!rx_sync)        frm_set = 1'b1;
                else if (!rx_par_bad) rx_good = 1'b1;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // A byte arriving at a full FIFO is lost unless TX frees a slot that same cycle.
    assign ovr_set = o_Rx_DV && fifo_full && !fifo_pop;

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            rx_meta      <= 1'b1;
            rx_sync      <= 1'b1;
            rx_state     <= RX_IDLE;
            rx_cnt       <= '0;
            rx_idx       <= '0;
            rx_shift     <= '0;
            rx_par_bad   <= 1'b0;
            o_Rx_DV      <= 1'b0;
            o_Rx_Byte    <= '0;
            o_Parity_Err <= 1'b0;
            o_Frame_Err  <= 1'b0;
            o_Overrun    <= 1'b0;
        end else begin
            rx_meta      <= i_Rx_Serial;
            rx_sync      <= rx_meta;
            rx_state     <= rx_state_d;
            rx_cnt       <= rx_cnt_d;
            rx_idx       <= rx_idx_d;
            rx_shift     <= rx_shift_d;
            rx_par_bad   <= rx_par_bad_d;
            o_Rx_DV      <= rx_good;
            if (rx_good) o_Rx_Byte <= rx_shift;
            o_Parity_Err <= par_set | (o_Parity_Err & ~i_Err_Clr);
            o_Frame_Err  <= frm_set | (o_Frame_Err & ~i_Err_Clr);
            o_Overrun    <= ovr_set | (o_Overrun & ~i_Err_Clr);
        end
    end

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (i_Clock),
        .rst_n   (i_Rst_n),
        .push    (o_Rx_DV),
        .wr_data (o_Rx_Byte),
        .pop     (fifo_pop),
        .rd_data (fifo_rd_dat),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (o_Fifo_Count)
    );

    always_comb begin
        tx_state_d = tx_state;
        tx_cnt_d   = tx_cnt + 1'b1;
        tx_idx_d   = tx_idx;
        tx_shift_d = tx_shift;
        tx_par_d   = tx_par;
        fifo_pop   = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                tx_cnt_d = '0;
                if (!fifo_empty && !i_Tx_Hold) begin
                    fifo_pop   = 1'b1;
                    tx_shift_d = fifo_rd_dat;
                    tx_state_d = TX_LOAD;
                end
            end
            TX_LOAD: begin
                tx_cnt_d   = '0;
                tx_idx_d   = '0;
                tx_par_d   = parity_bit(tx_pad, PMODE);
                tx_state_d = TX_START;
            end
            TX_START: if (tx_cnt == TX_LAST) begin
                tx_cnt_d   = '0;
                tx_state_d = TX_DATA;
            end
            TX_DATA: if (tx_cnt == TX_LAST) begin
                tx_cnt_d   = '0;
                tx_shift_d = {1'b0, tx_shift[DATA_BITS-1:1]};
                tx_idx_d   = tx_idx + 1'b1;
                if (tx_idx == IDX_LAST) tx_state_d = (PARITY_MODE != 0) ? TX_PARITY : TX_STOP;
            end
            TX_PARITY: if (tx_cnt == TX_LAST) begin
                tx_cnt_d   = '0;
                tx_state_d = TX_STOP;
            end
            TX_STOP: if (tx_cnt == STOP_LAST) begin
                tx_cnt_d   = '0;
                tx_state_d = TX_IDLE;
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_shift <= '0;
            tx_par   <= 1'b0;
        end else begin
            tx_state <= tx_state_d;
            tx_cnt   <= tx_cnt_d;
            tx_idx   <= tx_idx_d;
            tx_shift <= tx_shift_d;
            tx_par   <= tx_par_d;
        end
    end

    always_comb begin
        case (tx_state)
            TX_START:  o_Tx_Serial = 1'b0;
            TX_DATA:   o_Tx_Serial = tx_shift[0];
            TX_PARITY: o_Tx_Serial = tx_par;
            default:   o_Tx_Serial = 1'b1;
        endcase
    end

    assign o_Tx_Active = (tx_state == TX_START) || (tx_state == TX_DATA) ||
                         (tx_state == TX_PARITY) || (tx_state == TX_STOP);
    assign o_Tx_Done   = (tx_state == TX_STOP) && (tx_cnt == STOP_LAST);

endmodule

// File: tb/tb_uart_echo_fifo.sv
// Bench for uart_echo_fifo: instance A is 8N1, instance B is 8E2, both at 4 clocks per bit.
module tb_uart_echo_fifo;

    localparam int CPB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;
    logic rx_a = 1'b1, hold_a = 1'b0, clr_a = 1'b0;
    logic rx_b = 1'b1, hold_b = 1'b0, clr_b = 1'b0;
    logic dv_a, ser_a, act_a, done_a, perr_a, ferr_a, ovr_a;
    logic dv_b, ser_b, act_b, done_b, perr_b, ferr_b, ovr_b;
    logic [7:0] byte_a, byte_b;
    logic [4:0] cnt_a, cnt_b;

    uart_echo_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .FIFO_DEPTH(16)) dut_a (
        .i_Clock(clk), .i_Rst_n(rst_n), .i_Rx_Serial(rx_a), .i_Tx_Hold(hold_a), .i_Err_Clr(clr_a),
        .o_Rx_DV(dv_a), .o_Rx_Byte(byte_a), .o_Tx_Serial(ser_a), .o_Tx_Active(act_a), .o_Tx_Done(done_a),
        .o_Parity_Err(perr_a), .o_Frame_Err(ferr_a), .o_Overrun(ovr_a), .o_Fifo_Count(cnt_a));

    uart_echo_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(2), .FIFO_DEPTH(16)) dut_b (
        .i_Clock(clk), .i_Rst_n(rst_n), .i_Rx_Serial(rx_b), .i_Tx_Hold(hold_b), .i_Err_Clr(clr_b),
        .o_Rx_DV(dv_b), .o_Rx_Byte(byte_b), .o_Tx_Serial(ser_b), .o_Tx_Active(act_b), .o_Tx_Done(done_b),
        .o_Parity_Err(perr_b), .o_Frame_Err(ferr_b), .o_Overrun(ovr_b), .o_Fifo_Count(cnt_b));

    int n_pass = 0;
    int n_total = 0;
    logic [7:0] exp_rx_a[$], exp_rx_b[$], exp_tx_a[$], exp_tx_b[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Activity watchers: only these processes write the counters; the stimulus takes snapshots.
    int act_cyc_a = 0, act_cyc_b = 0, dv_cnt_a = 0, dv_cnt_b = 0, done_cnt_a = 0, done_cnt_b = 0;
    int run_a = 0, run_b = 0;
    bit prev_a = 0, prev_b = 0, seen_a = 0, seen_b = 0;
    int gaps_a[$], gaps_b[$];

    always @(negedge clk) begin
        if (act_a) act_cyc_a++;
        if (act_b) act_cyc_b++;
        if (dv_a) dv_cnt_a++;
        if (dv_b) dv_cnt_b++;
        if (done_a) done_cnt_a++;
        if (done_b) done_cnt_b++;
        if (act_a) begin
            if (!prev_a && seen_a) gaps_a.push_back(run_a);
            seen_a = 1; run_a = 0;
        end else run_a++;
        if (act_b) begin
            if (!prev_b && seen_b) gaps_b.push_back(run_b);
            seen_b = 1; run_b = 0;
        end else run_b++;
        prev_a = act_a;
        prev_b = act_b;
    end

    function automatic logic exp_bit(input int b, input logic [7:0] d, input bit par_en);
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        if (b == 9 && par_en) return ^d;
        return 1'b1;
    endfunction

    task automatic tx_mon(input bit inst);
        forever begin
            @(negedge clk);
            if (rst_n && (inst ? act_b : act_a)) begin
                logic [7:0] d;
                bit have, aborted;
                int nb, bad;
                have = 0; aborted = 0; bad = 0; d = '0;
                nb = inst ? 12 : 10;
                if (!inst && exp_tx_a.size() > 0) begin d = exp_tx_a.pop_front(); have = 1; end
                if (inst && exp_tx_b.size() > 0) begin d = exp_tx_b.pop_front(); have = 1; end
                for (int c = 0; c < nb * CPB; c++) begin
                    if (c > 0) @(negedge clk);
                    if (!rst_n) begin aborted = 1; break; end
                    if ((inst ? ser_b : ser_a) !== exp_bit(c / CPB, d, inst)) bad++;
                    if ((inst ? act_b : act_a) !== 1'b1) bad++;
                    if ((inst ? done_b : done_a) !== (c == nb * CPB - 1)) bad++;
                end
                if (!aborted) begin
                    check($sformatf("tx%s frame expected", inst ? "B" : "A"), 32'(have), 1);
                    if (have) check($sformatf("tx%s frame 0x%02h bad cycles", inst ? "B" : "A", d), bad, 0);
                end
            end
        end
    endtask

    task automatic rx_mon(input bit inst);
        forever begin
            @(negedge clk);
            if (rst_n && (inst ? dv_b : dv_a)) begin
                logic [7:0] e;
                bit have;
                have = 0; e = '0;
                if (!inst && exp_rx_a.size() > 0) begin e = exp_rx_a.pop_front(); have = 1; end
                if (inst && exp_rx_b.size() > 0) begin e = exp_rx_b.pop_front(); have = 1; end
                check($sformatf("rx%s byte expected", inst ? "B" : "A"), 32'(have), 1);
                if (have) check($sformatf("rx%s byte", inst ? "B" : "A"), 32'(inst ? byte_b : byte_a), 32'(e));
            end
        end
    endtask

    initial tx_mon(0);
    initial tx_mon(1);
    initial rx_mon(0);
    initial rx_mon(1);

    initial begin
        #500000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bit_time(input bit inst, input logic v);
        if (inst) rx_b = v; else rx_a = v;
        tick(CPB);
    endtask

    task automatic send_frame(input bit inst, input logic [7:0] d, input bit par_en, input logic par, input logic stop);
        bit_time(inst, 1'b0);
        for (int i = 0; i < 8; i++) bit_time(inst, d[i]);
        if (par_en) bit_time(inst, par);
        bit_time(inst, stop);
        bit_time(inst, 1'b1);
    endtask

    task automatic wait_idle(input int limit);
        int t;
        t = 0;
        while ((exp_tx_a.size() + exp_tx_b.size() + exp_rx_a.size() + exp_rx_b.size() > 0 || act_a || act_b)
               && t < limit) begin
            tick(1);
            t++;
        end
        check("all expected outputs seen", exp_tx_a.size() + exp_tx_b.size() + exp_rx_a.size() + exp_rx_b.size(), 0);
        check("tx returned idle", 32'(act_a | act_b), 0);
        tick(3);
    endtask

    int s0, s1, g0;

    initial begin
        tick(3);
        check("rst ser_a", 32'(ser_a), 1);
        check("rst ser_b", 32'(ser_b), 1);
        check("rst act", 32'({act_a, act_b, done_a, done_b}), 0);
        check("rst dv", 32'({dv_a, dv_b}), 0);
        check("rst byte", 32'({byte_a, byte_b}), 0);
        check("rst flags", 32'({perr_a, ferr_a, ovr_a, perr_b, ferr_b, ovr_b}), 0);
        check("rst count", 32'({cnt_a, cnt_b}), 0);
        rst_n = 1'b1;
        tick(4);

        // 8N1 echo of 0xA5
        s0 = done_cnt_a;
        exp_rx_a.push_back(8'hA5); exp_tx_a.push_back(8'hA5);
        send_frame(0, 8'hA5, 0, 1'b0, 1'b1);
        wait_idle(400);
        check("t1 tx_done pulses", done_cnt_a - s0, 1);
        check("t1 fifo count", 32'(cnt_a), 0);

        // Even parity: wrong parity dropped, flag clears, correct parity echoed
        s0 = act_cyc_b; s1 = dv_cnt_b;
        send_frame(1, 8'h03, 1, 1'b1, 1'b1);
        tick(4);
        check("t2 parity err set", 32'(perr_b), 1);
        check("t2 frame err clear", 32'(ferr_b), 0);
        check("t2 no rx_dv", dv_cnt_b - s1, 0);
        check("t2 fifo empty", 32'(cnt_b), 0);
        check("t2 tx idle", act_cyc_b - s0, 0);
        clr_b = 1'b1; tick(1); clr_b = 1'b0; tick(1);
        check("t2 parity err cleared", 32'(perr_b), 0);
        exp_rx_b.push_back(8'h03); exp_tx_b.push_back(8'h03);
        send_frame(1, 8'h03, 1, 1'b0, 1'b1);
        wait_idle(400);
        check("t2 parity err stays clear", 32'(perr_b), 0);

        // Frame error, then a second error coinciding with the clear pulse
        s1 = dv_cnt_a;
        send_frame(0, 8'h55, 0, 1'b0, 1'b0);
        tick(2);
        check("t3 frame err set", 32'(ferr_a), 1);
        check("t3 no rx_dv", dv_cnt_a - s1, 0);
        check("t3 fifo empty", 32'(cnt_a), 0);
        fork
            send_frame(0, 8'h55, 0, 1'b0, 1'b0);
            begin
                repeat (41) @(posedge clk);
                #1 clr_a = 1'b1;
                @(posedge clk);
                #1 clr_a = 1'b0;
            end
        join
        check("t3 set wins over clear", 32'(ferr_a), 1);
        clr_a = 1'b1; tick(1); clr_a = 1'b0; tick(1);
        check("t3 frame err cleared", 32'(ferr_a), 0);

        // Held TX: 18 bytes into a 16-deep FIFO, then drain
        hold_a = 1'b1;
        s0 = act_cyc_a;
        for (int i = 0; i < 18; i++) begin
            exp_rx_a.push_back(8'(i));
            if (i < 16) exp_tx_a.push_back(8'(i));
            send_frame(0, 8'(i), 0, 1'b0, 1'b1);
        end
        tick(2);
        check("t4 fifo full count", 32'(cnt_a), 16);
        check("t4 overrun", 32'(ovr_a), 1);
        check("t4 tx held", act_cyc_a - s0, 0);
        g0 = gaps_a.size();
        hold_a = 1'b0;
        wait_idle(2000);
        check("t4 frames after release", gaps_a.size() - g0, 16);
        for (int i = g0 + 1; i < gaps_a.size(); i++) check($sformatf("t4 gap %0d", i - g0), gaps_a[i], 2);
        check("t4 fifo drained", 32'(cnt_a), 0);
        check("t4 overrun sticky", 32'(ovr_a), 1);
        clr_a = 1'b1; tick(1); clr_a = 1'b0; tick(1);
        check("t4 overrun cleared", 32'(ovr_a), 0);

        // Two stop bits, back-to-back frames
        g0 = gaps_b.size();
        s0 = done_cnt_b;
        exp_rx_b.push_back(8'h81); exp_tx_b.push_back(8'h81);
        exp_rx_b.push_back(8'h07); exp_tx_b.push_back(8'h07);
        send_frame(1, 8'h81, 1, 1'b0, 1'b1);
        send_frame(1, 8'h07, 1, 1'b1, 1'b1);
        wait_idle(600);
        check("t5 frames", gaps_b.size() - g0, 2);
        if (gaps_b.size() - g0 == 2) check("t5 gap", gaps_b[g0 + 1], 2);
        check("t5 tx_done pulses", done_cnt_b - s0, 2);

        // Reset in the middle of a TX data bit
        exp_rx_a.push_back(8'h3C); exp_tx_a.push_back(8'h3C);
        send_frame(0, 8'h3C, 0, 1'b0, 1'b1);
        s0 = 0;
        while (!act_a && s0 < 50) begin tick(1); s0++; end
        check("t6 tx started", 32'(act_a), 1);
        tick(9);
        check("t6 data bit1 low", 32'(ser_a), 0);
        rst_n = 1'b0;
        #1;
        check("t6 rst ser", 32'(ser_a), 1);
        check("t6 rst act", 32'(act_a), 0);
        check("t6 rst count", 32'(cnt_a), 0);
        tick(3);
        rst_n = 1'b1;
        s0 = act_cyc_a; s1 = dv_cnt_a;
        tick(150);
        check("t6 no tx after reset", act_cyc_a - s0, 0);
        check("t6 no rx_dv after reset", dv_cnt_a - s1, 0);
        check("t6 line idle", 32'(ser_a), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
